mine_placer: RTL and testbench
==============================

# mine_placer

Sequencer that turns the free-running difficulty-sized random counters into a mine layout at the start of each game. On `start` it latches the difficulty, clears the board map, and samples the matching random value on each `sample_tick` until the difficulty's mine count is placed. Occupied cells are rejected and retried. It sits between the random-state counters and the board/game-logic blocks, which read `mine_map` once `done` pulses.

## Interface
- `MINES_EASY`, default 3: mines placed on the 16-cell board.
- `MINES_MEDIUM`, default 6: mines placed on the 32-cell board.
- `MINES_HARD`, default 10: mines placed on the 64-cell board.
- `Clk` input 1: single clock; all state is updated on its rising edge.
- `Reset` input 1: asynchronous, active-high.
- `start` input 1: request a new layout; sampled only in IDLE.
- `difficulty` input 2: 0 easy, 1 medium, 2 hard, 3 treated as hard; latched on accepted `start`.
- `sample_tick` input 1: placement attempt strobe, e.g. a keypress or frame event.
- `rand_easy` input 4, `rand_medium` input 5, `rand_hard` input 6: random counter values.
- `safe_cell` input 6: protected cell index; present only with the macro below.
- `busy` output 1: high in CLEAR and PLACE.
- `done` output 1: high for exactly one cycle, in the DONE state.
- `mine_map` output 64: bit i set means cell i is mined; bits at or above the board size are always 0.
- `mines_placed` output 4: count of mines placed so far.
- `reject_count` output 8: rejected attempts since the last `start`; saturates at 255.

## Operation
- States: IDLE, CLEAR, PLACE, DONE. Reset enters IDLE.
- Reset values: `busy`=0, `done`=0, `mine_map`=0, `mines_placed`=0, `reject_count`=0.
- IDLE:
  - `start`=1 moves to CLEAR and latches `difficulty` and the target mine count.
  - `mine_map` holds its previous layout.
- CLEAR (one cycle): `mine_map`, `mines_placed` and `reject_count` are zeroed; next state is PLACE.
- PLACE, on a cycle with `sample_tick`=1:
  - `idx` is the latched difficulty's random input, zero-extended to 6 bits.
  - If `mine_map[idx]`=0: set the bit and increment `mines_placed`. If the new count equals the target, go to DONE.
  - Otherwise increment `reject_count` (saturating at 255) and leave the map unchanged.
- PLACE with `sample_tick`=0: no change.
- DONE: `done`=1 for this one cycle, then IDLE.
- `start` outside IDLE is ignored, including in DONE.
- Changes to `difficulty` after latching have no effect until the next accepted `start`.
- There is no attempt limit: PLACE waits indefinitely for usable ticks.

## Timing
- Assume `start` high at cycle 0 and `sample_tick` high every cycle with no rejects.
  - Cycle 1: CLEAR.
  - Cycles 2 to 1+N: accepted placements. Each bit is visible in `mine_map` on the following cycle.
  - Cycle 2+N: `done`=1.
  - Cycle 3+N: back in IDLE, `busy`=0.
- Easy board (N=3): `done` at cycle 5.
- `Reset` asserted mid-operation immediately forces IDLE and clears all outputs.

## Configuration
- `MINE_PLACER_SAFE_CELL_EN` defined:
  - The `safe_cell` port exists.
  - An attempt with `idx`==`safe_cell` counts as a reject.
  - Targets must not exceed board size minus 1.
- `MINE_PLACER_SAFE_CELL_EN` undefined: no `safe_cell` port; every empty cell is eligible.

## Structure
- `game_pkg` holds:
  - The difficulty enum: EASY, MEDIUM, HARD.
  - Board cell-count constants: 16, 32, 64.
  - The placer state enum.
- One combinational sub-module, `mine_index_select`, does three things:
  - Selects and zero-extends the random value for the latched difficulty.
  - Applies the safe-cell exclusion.
  - Outputs `idx` and `idx_valid`.

## Test plan
- Easy layout: easy, ticks every cycle, `rand_easy` 5, 6, 7 on cycles 2, 3, 4.
  - Response: `mine_map`=0x00E0, `done` at cycle 5, `reject_count`=0.
- Duplicate rejection: easy, `rand_easy` held at 4 for 5 ticks.
  - Response: `mine_map`=0x0010, `mines_placed`=1, `reject_count`=4, still busy.
- Safe cell: macro on, `safe_cell`=6, `rand_easy` 5, 6, 7, 8.
  - Response: `mine_map`=0x01A0, `reject_count`=1, `done` asserted.
- Difficulty 3: `rand_hard` 40..49 on consecutive ticks.
  - Response: bits 40–49 set, `mines_placed`=10, one-cycle `done`.
- Reset mid-PLACE, after 2 mines placed: assert `Reset`.
  - Response: `mine_map`=0 and `busy`=0 immediately; a new `start` repeats the full sequence.
- `start` pulsed during PLACE and during DONE.
  - Response: no restart, layout unchanged, `reject_count` not cleared.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game types: difficulty and placer state enums, board cell counts.
// Pure declarations, no latency; no flow control involved.
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        EASY   = 2'd0,
        MEDIUM = 2'd1,
        HARD   = 2'd2
    } difficulty_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLACE = 2'd2,
        DONE  = 2'd3
    } placer_state_e;

    localparam int CELLS_EASY   = 16;
    localparam int CELLS_MEDIUM = 32;
    localparam int CELLS_HARD   = 64;
    localparam int IDX_W        = 6;

    // Encoding 3 has no board of its own and plays as hard.
    function automatic difficulty_e decode_difficulty(input logic [1:0] d);
        case (d)
            2'd0:    return EASY;
            2'd1:    return MEDIUM;
            default: return HARD;
        endcase
    endfunction

endpackage

// File: rtl/mine_index_select.sv
// Picks the random value for the latched difficulty and zero-extends it to a cell index.
// Latency: combinational. Backpressure: none, consumer samples idx when it wants.
// MINE_PLACER_SAFE_CELL_EN: idx_valid drops when idx hits the protected safe_cell.
module mine_index_select
    import game_pkg::*;
(
    input  difficulty_e                     difficulty,
    input  logic [$clog2(CELLS_EASY)-1:0]   rand_easy,
    input  logic [$clog2(CELLS_MEDIUM)-1:0] rand_medium,
    input  logic [$clog2(CELLS_HARD)-1:0]   rand_hard,
`ifdef MINE_PLACER_SAFE_CELL_EN
    input  logic [IDX_W-1:0]                safe_cell,
`endif
    output logic [IDX_W-1:0]                idx,
    output logic                            idx_valid
);

    always_comb begin
        idx       = IDX_W'(rand_hard);
        idx_valid = 1'b1;
        case (difficulty)
            EASY:    idx = IDX_W'(rand_easy);
            MEDIUM:  idx = IDX_W'(rand_medium);
            default: idx = IDX_W'(rand_hard);
        endcase
`ifdef MINE_PLACER_SAFE_CELL_EN
        if (idx == safe_cell) begin
            idx_valid = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/mine_placer.sv
// Builds a fresh mine layout per game: CLEAR then one placement attempt per sample_tick.
// Latency: done N+2 cycles after start with N reject-free ticks; one extra tick per reject.
// Backpressure: none; PLACE simply waits for ticks. Option macro MINE_PLACER_SAFE_CELL_EN.
module mine_placer
    import game_pkg::*;
#(
    parameter int MINES_EASY   = 3,
    parameter int MINES_MEDIUM = 6,
    parameter int MINES_HARD   = 10
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            start,
    input  logic [1:0]                      difficulty,
    input  logic                            sample_tick,
    input  logic [$clog2(CELLS_EASY)-1:0]   rand_easy,
    input  logic [$clog2(CELLS_MEDIUM)-1:0] rand_medium,
    input  logic [$clog2(CELLS_HARD)-1:0]   rand_hard,
`ifdef MINE_PLACER_SAFE_CELL_EN
    input  logic [IDX_W-1:0]                safe_cell,
`endif
    output logic                            busy,
    output logic                            done,
    output logic [CELLS_HARD-1:0]           mine_map,
    output logic [3:0]                      mines_placed,
    output logic [7:0]                      reject_count
);

`ifdef MINE_PLACER_SAFE_CELL_EN
    // One cell is always off limits, so a full board could never complete.
    localparam int LIM_EASY   = (MINES_EASY   > CELLS_EASY   - 1) ? CELLS_EASY   - 1 : MINES_EASY;
    localparam int LIM_MEDIUM = (MINES_MEDIUM > CELLS_MEDIUM - 1) ? CELLS_MEDIUM - 1 : MINES_MEDIUM;
    localparam int LIM_HARD   = (MINES_HARD   > CELLS_HARD   - 1) ? CELLS_HARD   - 1 : MINES_HARD;
`else
    localparam int LIM_EASY   = MINES_EASY;
    localparam int LIM_MEDIUM = MINES_MEDIUM;
    localparam int LIM_HARD   = MINES_HARD;
`endif

    function automatic logic [3:0] target_for(input difficulty_e d);
        case (d)
            EASY:    return 4'(LIM_EASY);
            MEDIUM:  return 4'(LIM_MEDIUM);
            default: return 4'(LIM_HARD);
        endcase
    endfunction

    placer_state_e    state, state_nxt;
    difficulty_e      diff_q;
    logic [3:0]       target_q;
    logic [IDX_W-1:0] idx;
    logic             idx_valid;
    logic             attempt;
    logic             accept;

    mine_index_select u_sel (
        .difficulty  (diff_q),
        .rand_easy   (rand_easy),
        .rand_medium (rand_medium),
        .rand_hard   (rand_hard),
`ifdef MINE_PLACER_SAFE_CELL_EN
        .safe_cell   (safe_cell),
`endif
        .idx         (idx),
        .idx_valid   (idx_valid)
    );

    assign attempt = (state == PLACE) && sample_tick;
    assign accept  = attempt && idx_valid && !mine_map[idx];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                busy      = 1'b1;
                state_nxt = PLACE;
            end
            PLACE: begin
                busy = 1'b1;
                if (accept && ((mines_placed + 4'd1) == target_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            diff_q       <= EASY;
            target_q     <= 4'd0;
            mine_map     <= '0;
            mines_placed <= 4'd0;
            reject_count <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        diff_q   <= decode_difficulty(difficulty);
                        target_q <= target_for(decode_difficulty(difficulty));
                    end
                end
                CLEAR: begin
                    mine_map     <= '0;
                    mines_placed <= 4'd0;
                    reject_count <= 8'd0;
                end
                PLACE: begin
                    if (accept) begin
                        mine_map[idx] <= 1'b1;
                        mines_placed  <= mines_placed + 4'd1;
                    end else if (attempt && (reject_count != 8'hFF)) begin
                        reject_count <= reject_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer: randomized games against a cell-set reference model with a
// done-triggered scoreboard, plus directed layouts, rejects, reset and stray-start cases.
module tb_mine_placer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [1:0]  difficulty;
    logic        sample_tick;
    logic [3:0]  rand_easy;
    logic [4:0]  rand_medium;
    logic [5:0]  rand_hard;
`ifdef MINE_PLACER_SAFE_CELL_EN
    logic [5:0]  safe_cell;
`endif
    logic        busy;
    logic        done;
    logic [63:0] mine_map;
    logic [3:0]  mines_placed;
    logic [7:0]  reject_count;

    mine_placer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .difficulty   (difficulty),
        .sample_tick  (sample_tick),
        .rand_easy    (rand_easy),
        .rand_medium  (rand_medium),
        .rand_hard    (rand_hard),
`ifdef MINE_PLACER_SAFE_CELL_EN
        .safe_cell    (safe_cell),
`endif
        .busy         (busy),
        .done         (done),
        .mine_map     (mine_map),
        .mines_placed (mines_placed),
        .reject_count (reject_count)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] map;
        int          placed;
        int          rej;
        int          done_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: a set of occupied cells and plain counters.
    int          m_occ[64];
    int          m_cnt, m_rej, m_target, m_board, m_diff;
    int          m_safe = -1;
    bit          m_active = 0;
    logic [63:0] m_last_map = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_safe(input int s);
`ifdef MINE_PLACER_SAFE_CELL_EN
        safe_cell = s[5:0];
        m_safe    = s;
`else
        m_safe    = -1 + 0 * s;
`endif
    endtask

    task automatic randomize_rands();
        rand_easy   = 4'($urandom);
        rand_medium = 5'($urandom);
        rand_hard   = 6'($urandom);
    endtask

    task automatic begin_game(input int d);
        start       = 1'b1;
        difficulty  = d[1:0];
        sample_tick = 1'($urandom_range(0, 1));
        randomize_rands();
        for (int i = 0; i < 64; i++) m_occ[i] = 0;
        m_cnt    = 0;
        m_rej    = 0;
        m_diff   = (d > 2) ? 2 : d;
        m_target = (m_diff == 0) ? 3 : (m_diff == 1) ? 6 : 10;
        m_board  = (m_diff == 0) ? 16 : (m_diff == 1) ? 32 : 64;
        m_active = 1;
        @(posedge Clk); #1;
        // Clearing cycle: tick and difficulty changes must be ignored here.
        start       = 1'b0;
        difficulty  = 2'($urandom);
        sample_tick = 1'b1;
        randomize_rands();
        @(posedge Clk); #1;
    endtask

    task automatic tick(input int v, input bit en, input bit st);
        logic [63:0] mp;
        exp_t        e;
        start       = st;
        sample_tick = en;
        difficulty  = 2'($urandom);
        randomize_rands();
        case (m_diff)
            0:       rand_easy   = v[3:0];
            1:       rand_medium = v[4:0];
            default: rand_hard   = v[5:0];
        endcase
        if (en && m_active) begin
            if (m_occ[v] != 0 || v == m_safe) begin
                m_rej = (m_rej < 255) ? m_rej + 1 : 255;
            end else begin
                m_occ[v] = 1;
                m_cnt++;
                if (m_cnt == m_target) begin
                    mp = '0;
                    for (int i = 0; i < 64; i++) if (m_occ[i] != 0) mp[i] = 1'b1;
                    e.map      = mp;
                    e.placed   = m_cnt;
                    e.rej      = m_rej;
                    e.done_cyc = cyc + 1;
                    sbq.push_back(e);
                    m_last_map = mp;
                    m_active   = 0;
                end
            end
        end
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_game(input bit start_in_done);
        int guard = 0;
        while (m_active && guard < 5000) begin
            tick($urandom_range(0, m_board - 1), $urandom_range(0, 3) != 0, 1'b0);
            guard++;
        end
        if (m_active) begin
            checks++;
            errors++;
            $display("FAIL game_bound: model still placing after %0d ticks, expected completion", guard);
            m_active = 0;
        end
        start       = start_in_done;
        sample_tick = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_map_hold", mine_map, m_last_map);
        tick($urandom_range(0, 63), 1'b1, 1'b0);
        chk("idle_map_hold2", mine_map, m_last_map);
    endtask

    always @(negedge Clk) begin
        if (!Reset && done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                chk("done_map", mine_map, mon_e.map);
                chk("done_placed", 64'(mines_placed), 64'(mon_e.placed));
                chk("done_rejects", 64'(reject_count), 64'(mon_e.rej));
                chk("done_busy", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        Reset       = 1'b1;
        start       = 1'b0;
        difficulty  = 2'd0;
        sample_tick = 1'b0;
        rand_easy   = '0;
        rand_medium = '0;
        rand_hard   = '0;
        set_safe(63);
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_map", mine_map, 64'd0);
        chk("rst_placed", 64'(mines_placed), 64'd0);
        chk("rst_rejects", 64'(reject_count), 64'd0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        // Easy layout 5,6,7: done five cycles after start.
        begin_game(0);
        chk("easy_busy", 64'(busy), 64'd1);
        tick(5, 1'b1, 1'b0);
        tick(6, 1'b1, 1'b0);
        tick(7, 1'b1, 1'b0);
        chk("easy_map", mine_map, 64'h00E0);
        finish_game(1'b0);

        // Duplicate rejection, then start pulsed in DONE.
        begin_game(0);
        repeat (5) tick(4, 1'b1, 1'b0);
        chk("dup_map", mine_map, 64'h0010);
        chk("dup_placed", 64'(mines_placed), 64'd1);
        chk("dup_rejects", 64'(reject_count), 64'd4);
        chk("dup_busy", 64'(busy), 64'd1);
        finish_game(1'b1);

        // Start pulsed during PLACE must not restart or clear rejects.
        begin_game(1);
        tick(3, 1'b1, 1'b0);
        tick(3, 1'b1, 1'b1);
        tick(3, 1'b1, 1'b0);
        chk("stray_map", mine_map, 64'h0008);
        chk("stray_rejects", 64'(reject_count), 64'd2);
        chk("stray_busy", 64'(busy), 64'd1);
        finish_game(1'b1);

        // Difficulty 3 plays as hard.
        begin_game(3);
        for (int i = 40; i < 50; i++) tick(i, 1'b1, 1'b0);
        chk("hard_map", mine_map, 64'h0003_FF00_0000_0000);
        finish_game(1'b0);

        // Reset in the middle of placement.
        begin_game(0);
        tick(1, 1'b1, 1'b0);
        tick(2, 1'b1, 1'b0);
        Reset = 1'b1;
        #1;
        chk("midrst_map", mine_map, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_placed", 64'(mines_placed), 64'd0);
        chk("midrst_rejects", 64'(reject_count), 64'd0);
        m_active   = 0;
        m_last_map = '0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        begin_game(0);
        tick(1, 1'b1, 1'b0);
        tick(2, 1'b1, 1'b0);
        tick(3, 1'b1, 1'b0);
        finish_game(1'b0);

        // Reject counter saturation.
        begin_game(0);
        tick(0, 1'b1, 1'b0);
        repeat (300) tick(0, 1'b1, 1'b0);
        chk("sat_rejects", 64'(reject_count), 64'd255);
        finish_game(1'b0);

`ifdef MINE_PLACER_SAFE_CELL_EN
        set_safe(6);
        begin_game(0);
        tick(5, 1'b1, 1'b0);
        tick(6, 1'b1, 1'b0);
        tick(7, 1'b1, 1'b0);
        tick(8, 1'b1, 1'b0);
        finish_game(1'b0);
        chk("safe_map", mine_map, 64'h01A0);
        chk("safe_rejects", 64'(reject_count), 64'd1);
`endif

        // Randomized games with random idle gaps.
        repeat (30) begin
            set_safe($urandom_range(0, 63));
            repeat ($urandom_range(0, 3)) tick($urandom_range(0, 63), 1'($urandom), 1'b0);
            begin_game($urandom_range(0, 3));
            finish_game(1'($urandom));
        end

        repeat (3) @(posedge Clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
